vector_scale: RTL and testbench

Multiplies every element of an IEEE-754 single-precision vector by one scalar, producing a vector: the scalar-to-vector counterpart of `dot_product`, which reduces two vectors to a scalar. It time-multiplexes a single fp32 multiplier over the elements, one element per clock. It uses the same start/`done` convention as the vector blocks, so it can feed a `dot_product` stage directly.

---
 rtl/vector_scale_if.sv | 21 ++
 rtl/vector_scale.sv | 128 ++++++++++++
 tb/tb_vector_scale.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_scale_if.sv
// Start/done handshake and operand/result bundle for vector_scale.
interface vector_scale_if #(
  parameter int unsigned VECTOR_LEN = 4
);
  logic                         start;
  logic [31:0]                  scalar;
  logic [VECTOR_LEN-1:0][31:0]  vec;
  logic [VECTOR_LEN-1:0][31:0]  result;
  logic                         busy;
  logic                         done;

  modport master (
    output start, scalar, vec,
    input  result, busy, done
  );

  modport slave (
    input  start, scalar, vec,
    output result, busy, done
  );
endinterface

// File: rtl/vector_scale.sv
// Fp32 vector-by-scalar multiply: one shared combinational fp32 multiplier, one element per clock.
module vector_scale #(
  parameter int unsigned VECTOR_LEN = 4
) (
  input logic           clk,
  input logic           rst,
  vector_scale_if.slave bus
);

  localparam int unsigned IdxW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(VECTOR_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                      state_q;
  logic [IdxW-1:0]             idx_q;
  logic [31:0]                 scalar_q;
  logic [VECTOR_LEN-1:0][31:0] vec_q;
  logic [VECTOR_LEN-1:0][31:0] result_q;
  logic                        busy_q;
  logic                        done_q;
  logic [31:0]                 prod;

  // Subnormals in and out are flushed to signed zero; rounding is nearest-even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sign;
    logic [7:0]        ea, eb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       mprod;
    logic [24:0]       mant;
    logic              guard, sticky;
    logic signed [9:0] exp;
    logic [31:0]       res;

    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

    mprod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    if (mprod[47]) begin
      mant   = {1'b0, mprod[47:24]};
      guard  = mprod[23];
      sticky = |mprod[22:0];
      exp    = exp + 10'sd1;
    end else begin
      mant   = {1'b0, mprod[46:23]};
      guard  = mprod[22];
      sticky = |mprod[21:0];
    end

    if (guard && (sticky || mant[0])) begin
      mant = mant + 25'd1;
    end
    if (mant[24]) begin
      mant = mant >> 1;
      exp  = exp + 10'sd1;
    end

    res = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      res = {sign, 31'd0};
    end else if (exp >= 10'sd255) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (exp <= 10'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, exp[7:0], mant[22:0]};
    end
    return res;
  endfunction

  assign prod = fp_mul(scalar_q, vec_q[idx_q]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      scalar_q <= '0;
      vec_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            scalar_q <= bus.scalar;
            vec_q    <= bus.vec;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          // start is deliberately ignored here; operands stay as latched
          result_q[idx_q] <= prod;
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_vector_scale.sv
// Self-checking bench for vector_scale: directed cases plus random operands against a real-valued model.
module tb_vector_scale;

  localparam int VL    = 4;
  localparam int Limit = 4 * VL + 8;

  typedef logic [VL-1:0][31:0] vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t last_exp;

  vector_scale_if #(.VECTOR_LEN(VL)) bus ();

  vector_scale #(.VECTOR_LEN(VL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic real fp_mag(input logic [31:0] x);
    return (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
  endfunction

  // Exact product in double, then rounded to 24 significant bits by hand.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   sign;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    real    p, m, fl;
    int     e, biased;
    longint mi;
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {sign, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {sign, 31'd0};
    p = fp_mag(a) * fp_mag(b);
    e = 0;
    while (p >= 2.0) begin p = p / 2.0; e++; end
    while (p < 1.0) begin p = p * 2.0; e--; end
    m  = p * 8388608.0;
    fl = $floor(m);
    mi = longint'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && mi[0])) mi++;
    if (mi == 64'sd16777216) begin
      mi = 64'sd8388608;
      e++;
    end
    biased = e + 127;
    if (biased >= 255) return {sign, 8'hFF, 23'd0};
    if (biased <= 0) return {sign, 31'd0};
    return {sign, biased[7:0], mi[22:0]};
  endfunction

  function automatic vec_t ref_vec(input logic [31:0] s, input vec_t v);
    vec_t r;
    for (int i = 0; i < VL; i++) r[i] = ref_mul(s, v[i]);
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 11))
      0:       x[30:23] = 8'h00;
      1:       begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      2:       x[30:23] = 8'hFF;
      3:       x[30:23] = 8'($urandom_range(1, 40));
      4:       x[30:23] = 8'($urandom_range(200, 254));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VL; i++) v[i] = rand_fp();
    return v;
  endfunction

  // Returns #1 after the edge that samples start.
  task automatic launch(input logic [31:0] s, input vec_t v);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.scalar = s;
    bus.vec    = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && lat < Limit) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cycles++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    bus.start  = 1'b1;
    bus.scalar = $urandom;
    bus.vec    = rand_vec();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h required 0", bus.result);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b required 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b required 0", bus.done);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy got %b required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    vec_t v;
    int   lat, bc;
    for (int i = 0; i < VL; i++) v[i] = 32'h3F80_0000;
    launch(32'h4000_0000, v);
    wait_done(lat, bc);
    checks++;
    if (lat != VL) begin
      failures++;
      $display("FAIL basic_latency: got %0d required %0d", lat, VL);
    end
    checks++;
    if (bc != VL) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d required %0d", bc, VL);
    end
    for (int i = 0; i < VL; i++) begin
      checks++;
      if (bus.result[i] !== 32'h4000_0000) begin
        failures++;
        $display("FAIL basic_r%0d: got %h required 40000000", i, bus.result[i]);
      end
      last_exp[i] = 32'h4000_0000;
    end
  endtask

  // Elements appear one per edge; unwritten ones keep the previous operation's value.
  task automatic test_latency();
    logic [31:0] s;
    vec_t        v, expv, want;
    s    = rand_fp();
    v    = rand_vec();
    expv = ref_vec(s, v);
    launch(s, v);
    for (int k = 1; k <= VL; k++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < VL; j++) want[j] = (j < k) ? expv[j] : last_exp[j];
      checks++;
      if (bus.result !== want) begin
        failures++;
        $display("FAIL latency_edge%0d: got %h required %h", k, bus.result, want);
      end
      checks++;
      if (bus.busy !== (k < VL) || bus.done !== (k == VL)) begin
        failures++;
        $display("FAIL latency_flags%0d: got busy=%b done=%b required busy=%b done=%b",
                 k, bus.busy, bus.done, k < VL, k == VL);
      end
    end
    last_exp = expv;
  endtask

  task automatic test_signs();
    vec_t v, want;
    int   lat, bc;
    v[0] = 32'h4040_0000; v[1] = 32'hBF80_0000; v[2] = 32'h0000_0000; v[3] = 32'h0000_0001;
    want[0] = 32'hBFC0_0000; want[1] = 32'h3F00_0000;
    want[2] = 32'h8000_0000; want[3] = 32'h8000_0000;
    launch(32'hBF00_0000, v);
    wait_done(lat, bc);
    for (int i = 0; i < VL; i++) begin
      checks++;
      if (bus.result[i] !== want[i]) begin
        failures++;
        $display("FAIL signs_r%0d: got %h required %h", i, bus.result[i], want[i]);
      end
    end
  endtask

  task automatic test_specials();
    vec_t v, want;
    int   lat, bc;
    v[0] = 32'h0000_0000; v[1] = 32'hC000_0000; v[2] = 32'h7FC0_0001; v[3] = 32'h3F80_0000;
    want[0] = 32'h7FC0_0000; want[1] = 32'hFF80_0000;
    want[2] = 32'h7FC0_0000; want[3] = 32'h7F80_0000;
    launch(32'h7F80_0000, v);
    wait_done(lat, bc);
    for (int i = 0; i < VL; i++) begin
      checks++;
      if (bus.result[i] !== want[i]) begin
        failures++;
        $display("FAIL specials_r%0d: got %h required %h", i, bus.result[i], want[i]);
      end
    end
  endtask

  // 0x006CE3EE has a zero exponent field, so it multiplies as +0.
  task automatic test_range();
    vec_t v, want;
    int   lat, bc;
    v[0] = 32'h7E96_7699; v[1] = 32'h006C_E3EE; v[2] = 32'h3F80_0001; v[3] = 32'h3F80_0000;
    want[0] = 32'h7F80_0000; want[1] = 32'h0000_0000;
    want[2] = ref_mul(32'h7E96_7699, 32'h3F80_0001); want[3] = 32'h7E96_7699;
    launch(32'h7E96_7699, v);
    wait_done(lat, bc);
    for (int i = 0; i < VL; i++) begin
      checks++;
      if (bus.result[i] !== want[i]) begin
        failures++;
        $display("FAIL range_big_r%0d: got %h required %h", i, bus.result[i], want[i]);
      end
    end
    want[0] = ref_mul(32'h3F80_0001, 32'h7E96_7699); want[1] = 32'h0000_0000;
    want[2] = 32'h3F80_0002; want[3] = 32'h3F80_0001;
    launch(32'h3F80_0001, v);
    wait_done(lat, bc);
    for (int i = 0; i < VL; i++) begin
      checks++;
      if (bus.result[i] !== want[i]) begin
        failures++;
        $display("FAIL range_rne_r%0d: got %h required %h", i, bus.result[i], want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    vec_t        v, want;
    int          lat, bc;
    for (int n = 0; n < 16; n++) begin
      s    = rand_fp();
      v    = rand_vec();
      want = ref_vec(s, v);
      launch(s, v);
      wait_done(lat, bc);
      checks++;
      if (lat != VL) begin
        failures++;
        $display("FAIL random%0d_latency: got %0d required %0d", n, lat, VL);
      end
      for (int i = 0; i < VL; i++) begin
        checks++;
        if (bus.result[i] !== want[i]) begin
          failures++;
          $display("FAIL random%0d_r%0d: %h*%h got %h required %h",
                   n, i, s, v[i], bus.result[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] sa, sb;
    vec_t        va, vb, want;
    sa   = rand_fp();
    va   = rand_vec();
    sb   = rand_fp();
    vb   = rand_vec();
    want = ref_vec(sa, va);
    launch(sa, va);
    for (int k = 1; k <= VL; k++) begin
      if (k == 2) begin
        @(negedge clk);
        bus.start  = 1'b1;
        bus.scalar = sb;
        bus.vec    = vb;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.done !== (k == VL)) begin
        failures++;
        $display("FAIL ignore_done_edge%0d: got %b required %b", k, bus.done, k == VL);
      end
    end
    checks++;
    if (bus.result !== want) begin
      failures++;
      $display("FAIL ignore_result: got %h required %h", bus.result, want);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== want) begin
      failures++;
      $display("FAIL done_hold: got done=%b busy=%b result=%h required done=1 busy=0 result=%h",
               bus.done, bus.busy, bus.result, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa, sb;
    vec_t        va, vb, wa, wb;
    int          low;
    sa = rand_fp();
    va = rand_vec();
    sb = rand_fp();
    vb = rand_vec();
    wa = ref_vec(sa, va);
    wb = ref_vec(sb, vb);
    launch(sa, va);
    for (int k = 1; k < VL; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.scalar = sb;
    bus.vec    = vb;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.result !== wa) begin
      failures++;
      $display("FAIL b2b_first: got done=%b result=%h required done=1 result=%h",
               bus.done, bus.result, wa);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got done=%b busy=%b required done=0 busy=1",
               bus.done, bus.busy);
    end
    low = 1;
    while (!bus.done && low < Limit) begin
      @(posedge clk);
      #1;
      if (!bus.done) low++;
    end
    checks++;
    if (low != VL) begin
      failures++;
      $display("FAIL b2b_done_low: got %0d cycles required %0d", low, VL);
    end
    checks++;
    if (bus.result !== wb) begin
      failures++;
      $display("FAIL b2b_second: got %h required %h", bus.result, wb);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] s;
    vec_t        v, want;
    int          lat, bc;
    launch(rand_fp(), rand_vec());
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.result !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: got result=%h busy=%b done=%b required all 0",
               bus.result, bus.busy, bus.done);
    end
    #3;
    rst  = 1'b1;
    s    = rand_fp();
    v    = rand_vec();
    want = ref_vec(s, v);
    launch(s, v);
    wait_done(lat, bc);
    checks++;
    if (lat != VL || bus.result !== want) begin
      failures++;
      $display("FAIL midop_recover: got lat=%0d result=%h required lat=%0d result=%h",
               lat, bus.result, VL, want);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.scalar = '0;
    bus.vec    = '0;
    test_reset();
    test_basic();
    test_latency();
    test_signs();
    test_specials();
    test_range();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
